// File: rtl/mips_dmem_adapter.sv
// mips_dmem_adapter: bridges the MIPS MEM stage to a single-beat 32-bit bus master.
// Handles byte/half/word lane steering, write-data replication, read extraction
// with sign/zero extension and a bus-ack timeout.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mips_dmem_adapter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    output logic        mem_timeout,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic        r_timeout;
    logic [31:0] r_din;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_dout;
    logic [1:0]  r_type;
    logic        r_ext;
    logic [1:0]  r_lane;

    logic        w_req;
    logic        w_misalign;
    logic        w_timeout_hit;
    logic        w_stall;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_req         = mem_ren | mem_wen;
    assign w_timeout_hit = (r_count == 16'(TIMEOUT_CYCLES - 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((mem_type == 2'b01) && mem_addr[0]) ||
                        (((mem_type == 2'b00) || (mem_type == 2'b11)) && (mem_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte-lane enables and replicated write data for the requested access size
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_dout;
        case (mem_type)
            2'b01: begin
                w_sel   = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_dout[15:0]}};
            end
            2'b10: begin
                w_sel   = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_dout[7:0]}};
            end
            default: begin
            end
        endcase
    end

    // Pick the addressed lane out of the bus word and right-align/extend it
    always_comb begin
        w_rdata = bus_din;
        w_half  = r_lane[1] ? bus_din[31:16] : bus_din[15:0];
        w_byte  = bus_din[{r_lane, 3'b000} +: 8];
        case (r_type)
            2'b01:   w_rdata = {{16{r_ext & w_half[15]}}, w_half};
            2'b10:   w_rdata = {{24{r_ext & w_byte[7]}}, w_byte};
            default: w_rdata = bus_din;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and stall decode
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    w_next  = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (bus_ack || w_timeout_hit) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the bus request on entry to REQ, then capture data or time out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_timeout  <= 1'b0;
            r_din      <= '0;
            r_bus_we   <= 1'b0;
            r_bus_sel  <= '0;
            r_bus_addr <= '0;
            r_bus_dout <= '0;
            r_type     <= '0;
            r_ext      <= 1'b0;
            r_lane     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && w_misalign) begin
                        r_din <= '0;
                    end else if (w_req) begin
                        r_bus_addr <= {mem_addr[31:2], 2'b00};
                        r_bus_we   <= mem_wen;
                        r_bus_sel  <= w_sel;
                        r_bus_dout <= w_wdata;
                        r_type     <= mem_type;
                        r_ext      <= mem_ext;
                        r_lane     <= mem_addr[1:0];
                        r_count    <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        r_din <= w_rdata;
                    end else if (w_timeout_hit) begin
                        r_din     <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_unalign;

    // Raise the misalignment exception for the DONE cycle that follows the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_unalign <= 1'b0;
        else        r_unalign <= (r_state == IDLE) && w_req && w_misalign;
    end

    assign mem_unalign = r_unalign;
`else
    assign mem_unalign = 1'b0;
`endif

    assign mem_stall   = rst_n & w_stall;
    assign mem_timeout = r_timeout;
    assign mem_din     = r_din;
    assign bus_cyc     = (r_state == REQ);
    assign bus_stb     = (r_state == REQ);
    assign bus_we      = r_bus_we;
    assign bus_sel     = r_bus_sel;
    assign bus_addr    = r_bus_addr;
    assign bus_dout    = r_bus_dout;

endmodule

// File: doc/mips_dmem_adapter.md
MIPS_DMEM_ADAPTER -- requirements
Module: mips_dmem_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, bus cycles to wait for bus_ack before aborting (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_ren  input  1  CPU MEM-stage read request (level).
REQ-005 SHALL have port mem_wen  input  1  CPU MEM-stage write request (level); wins over mem_ren when both are high.
REQ-006 SHALL have port mem_type  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 SHALL have port mem_ext  input  1  sign-extend (1) or zero-extend (0) half/byte read data.
REQ-008 SHALL have port mem_addr  input  32  byte address.
REQ-009 SHALL have port mem_dout  input  32  CPU write data, right-aligned.
REQ-010 SHALL have port mem_din  output  32  extended read data returned to the CPU.
REQ-011 SHALL have port mem_stall  output  1  holds the CPU pipeline while an access is outstanding.
REQ-012 SHALL have port mem_unalign  output  1  one-cycle misaligned-access exception pulse.
REQ-013 SHALL have port mem_timeout  output  1  one-cycle bus-timeout exception pulse.
REQ-014 SHALL have ports bus_cyc/bus_stb/bus_we (output, 1 each), bus_sel (output, 4), bus_addr (output, 32), bus_dout (output, 32), bus_din (input, 32), bus_ack (input, 1), forming a single-beat 32-bit bus master.

Function
REQ-015 SHALL implement FSM states IDLE, REQ and DONE.
REQ-016 IDLE: with mem_ren|mem_wen high, SHALL assert mem_stall combinationally and go to REQ, or to DONE for a misaligned access; otherwise SHALL stay in IDLE with mem_stall=0.
REQ-017 REQ: bus_cyc=bus_stb=1, mem_stall=1; bus_addr={mem_addr[31:2],2'b00} and bus_we/bus_sel/bus_dout SHALL be registered on entry and held stable.
REQ-018 REQ with bus_ack=1 SHALL capture bus_din and go to DONE; bus_cyc/bus_stb SHALL be 0 on the following cycle.
REQ-019 REQ SHALL count cycles without ack; if the count reaches TIMEOUT_CYCLES, SHALL drop bus_cyc/bus_stb and go to DONE with mem_timeout=1 and mem_din=0.
REQ-020 DONE SHALL last exactly one cycle with mem_stall=0, presenting mem_din and any exception pulse, then return to IDLE.
REQ-021 A request still present in IDLE after DONE SHALL be treated as a new access.
REQ-022 Minimum latency: request seen in IDLE, bus_ack in first REQ cycle, data in DONE, i.e. 2 stall cycles.
REQ-023 Byte lanes SHALL be little-endian: byte n (addr[1:0]=n) maps to bits [8n+7:8n], sel bit n; half uses sel 0011 (addr[1]=0) or 1100; word uses 1111.
REQ-024 Write data SHALL be replicated: byte on all 4 lanes, half on both halves.
REQ-025 Read data SHALL be lane-selected, right-aligned and extended per mem_ext; word reads SHALL pass through unchanged.
REQ-026 mem_din SHALL hold its last value outside DONE.
REQ-027 A bus_ack arriving outside REQ SHALL be ignored.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, every output 0 (mem_din, mem_stall, mem_unalign, mem_timeout, all bus outputs), asynchronously.
REQ-029 Reset during REQ SHALL drop bus_cyc/bus_stb immediately; the aborted access SHALL NOT be retried.

Configuration
REQ-030 With MEM_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no bus cycle and SHALL go IDLE->DONE with mem_unalign=1 and mem_din=0.
REQ-031 Without MEM_ALIGN_CHECK_EN, misaligned low address bits SHALL be ignored (half uses addr[1] only, word uses neither) and mem_unalign SHALL be tied 0.

Verification
REQ-032 Word read at 0x100, bus_din=0xDEADBEEF, ack in first REQ cycle -> bus_sel=1111, bus_addr=0x100, 2 stall cycles, mem_din=0xDEADBEEF in DONE.
REQ-033 Byte read at 0x103 with mem_ext=1, bus_din=0x80xxxxxx -> mem_din=0xFFFFFF80; with mem_ext=0 -> 0x00000080.
REQ-034 Half write at 0x202, mem_dout=0x0000ABCD -> bus_we=1, bus_sel=1100, bus_dout=0xABCDABCD, bus_addr=0x200.
REQ-035 Read with no ack and TIMEOUT_CYCLES=4 -> bus_stb high 4 cycles, then mem_timeout pulses 1 cycle, mem_din=0, mem_stall released.
REQ-036 With MEM_ALIGN_CHECK_EN, word read at 0x101 -> bus_cyc never asserted, mem_unalign pulses 1 cycle after the request; without the macro -> normal read at 0x100.
REQ-037 rst_n low during REQ -> bus_cyc=0 and all outputs 0 immediately; after release, IDLE and the next request serviced normally.
